// File: rtl/mac_fifo_writer.sv
// Signed multiply-accumulate stage that sums K consecutive products per result
// and writes each result into a downstream fifo_out, honouring its free-space count.
module mac_fifo_writer #(
  parameter int INW   = 8,
  parameter int OUTW  = 24,
  parameter int K     = 4,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INW-1:0]               a_in,
  input  logic [INW-1:0]               b_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [OUTW-1:0]              data_out,
  output logic                         wr_en,
  input  logic [$clog2(DEPTH+1)-1:0]   capacity
);

  localparam int PW = 2 * INW;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  logic [CW-1:0]          cnt_q, cnt_d;
  logic signed [PW-1:0]   prod_q, prod_d;
  logic                   p_valid_q, p_valid_d;
  logic                   p_first_q, p_first_d;
  logic                   p_last_q, p_last_d;
  logic [OUTW-1:0]        acc_q, acc_d;
  logic [OUTW-1:0]        res_q, res_d;
  logic                   res_valid_q, res_valid_d;

  logic                   en;
  logic                   accept;
  logic                   cnt_last;
  logic [OUTW-1:0]        prod_ext;
  logic [OUTW-1:0]        sum;

  // Whole pipeline freezes only when a finished result cannot be handed off.
  assign en       = !res_valid_q || (capacity != '0);
  assign in_ready = en && !reset;
  assign accept   = in_valid && in_ready;
  assign wr_en    = res_valid_q && (capacity != '0);
  assign data_out = res_q;

  assign cnt_last = (cnt_q == CW'(K - 1));
  // Size cast of a signed operand sign-extends or truncates as needed.
  assign prod_ext = OUTW'(prod_q);
  assign sum      = (p_first_q ? '0 : acc_q) + prod_ext;

  always_comb begin
    cnt_d       = cnt_q;
    prod_d      = prod_q;
    p_valid_d   = p_valid_q;
    p_first_d   = p_first_q;
    p_last_d    = p_last_q;
    acc_d       = acc_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;

    if (wr_en) begin
      res_valid_d = 1'b0;
    end

    if (en) begin
      p_valid_d = accept;
      if (accept) begin
        prod_d    = PW'($signed(a_in)) * PW'($signed(b_in));
        p_first_d = (cnt_q == '0);
        p_last_d  = cnt_last;
        cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
      end
      if (p_valid_q) begin
        acc_d = sum;
        if (p_last_q) begin
          res_d       = sum;
          res_valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= '0;
      prod_q      <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      acc_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prod_q      <= prod_d;
      p_valid_q   <= p_valid_d;
      p_first_q   <= p_first_d;
      p_last_q    <= p_last_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule

// File: tb/tb_mac_fifo_writer.sv
// Bench for mac_fifo_writer: vector table, hand-written corner sequences,
// and a randomized soak against a group-sum model feeding a FIFO occupancy model.
module tb_mac_fifo_writer;

  localparam int INW   = 8;
  localparam int OUTW  = 24;
  localparam int K     = 4;
  localparam int DEPTH = 8;
  localparam int CAPW  = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset;
  logic [INW-1:0]  a_in, b_in;
  logic            in_valid, in_ready, wr_en;
  logic [OUTW-1:0] data_out;
  logic [CAPW-1:0] capacity;

  logic            w_reset;
  logic [INW-1:0]  w_a, w_b;
  logic            w_valid, w_ready, w_wr;
  logic [15:0]     w_data;
  logic [CAPW-1:0] w_cap;

  mac_fifo_writer #(.INW(INW), .OUTW(OUTW), .K(K), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .in_valid(in_valid),
    .in_ready(in_ready), .data_out(data_out), .wr_en(wr_en), .capacity(capacity)
  );

  mac_fifo_writer #(.INW(INW), .OUTW(16), .K(4), .DEPTH(DEPTH)) dut_w (
    .clk(clk), .reset(w_reset), .a_in(w_a), .b_in(w_b), .in_valid(w_valid),
    .in_ready(w_ready), .data_out(w_data), .wr_en(w_wr), .capacity(w_cap)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  typedef struct {
    bit              rst;
    bit              v;
    logic [INW-1:0]  a;
    logic [INW-1:0]  b;
    logic [CAPW-1:0] cap;
    bit              e_rdy;
    bit              e_wr;
    logic [OUTW-1:0] e_data;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input bit rst, input bit v, input int a, input int b, input int cap,
                      input bit er, input bit ew, input int ed);
    vec_t t;
    t.rst = rst; t.v = v; t.a = INW'(a); t.b = INW'(b); t.cap = CAPW'(cap);
    t.e_rdy = er; t.e_wr = ew; t.e_data = OUTW'(ed);
    tbl.push_back(t);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  int mask;

  initial begin
    mask = (1 << OUTW) - 1;
    reset = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; capacity = CAPW'(DEPTH);
    w_reset = 1'b1; w_valid = 1'b0; w_a = '0; w_b = '0; w_cap = CAPW'(DEPTH);
    repeat (2) @(posedge clk);
    #1;
    w_reset = 1'b0;

    // Basic sum then backpressure, one row per cycle.
    addv(1, 0, 0, 0, 8, 0, 0, 0);
    addv(0, 1, 1, 1, 8, 1, 0, 0);
    addv(0, 1, 2, 3, 8, 1, 0, 0);
    addv(0, 1, -1, 5, 8, 1, 0, 0);
    addv(0, 1, 4, 4, 8, 1, 0, 0);
    addv(0, 0, 0, 0, 8, 1, 0, 0);
    addv(0, 0, 0, 0, 8, 1, 1, 18);
    addv(0, 0, 0, 0, 8, 1, 0, 18);
    for (int i = 0; i < 4; i++) addv(0, 1, 1, 1, 0, 1, 0, 18);
    addv(0, 0, 0, 0, 0, 1, 0, 18);
    for (int i = 0; i < 10; i++) addv(0, 1, 2, 2, 0, 0, 0, 4);
    addv(0, 1, 2, 2, 1, 1, 1, 4);
    addv(0, 0, 0, 0, 1, 1, 0, 4);

    foreach (tbl[i]) begin
      reset = tbl[i].rst; in_valid = tbl[i].v; a_in = tbl[i].a; b_in = tbl[i].b;
      capacity = tbl[i].cap;
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), in_ready, tbl[i].e_rdy);
      check($sformatf("vec%0d_wr_en", i), wr_en, tbl[i].e_wr);
      check($sformatf("vec%0d_data", i), data_out, tbl[i].e_data);
      @(posedge clk); #1;
    end

    // Throughput: three back-to-back groups of (1,1).
    begin
      int acc_n = 0, nwr = 0, rdy_ok = 1;
      int wcyc[$];
      logic [OUTW-1:0] wdat[$];
      capacity = CAPW'(DEPTH);
      do_reset();
      for (int c = 0; c < 30; c++) begin
        in_valid = (acc_n < 12); a_in = 8'd1; b_in = 8'd1;
        @(negedge clk);
        if (in_valid && !in_ready) rdy_ok = 0;
        if (in_valid && in_ready) acc_n++;
        if (wr_en) begin wcyc.push_back(c); wdat.push_back(data_out); nwr++; end
        @(posedge clk); #1;
      end
      check("thru_ready", rdy_ok, 1);
      check("thru_nwr", nwr, 3);
      if (nwr == 3) begin
        for (int i = 0; i < 3; i++) check($sformatf("thru_data%0d", i), wdat[i], 4);
        check("thru_first_cycle", wcyc[0], 5);
        check("thru_gap1", wcyc[1] - wcyc[0], 4);
        check("thru_gap2", wcyc[2] - wcyc[1], 4);
      end
    end

    // Reset mid-group discards the partial sum.
    begin
      int nwr = 0, sent = 0;
      logic [OUTW-1:0] last_d = '0;
      do_reset();
      in_valid = 1'b1; a_in = 8'd5; b_in = 8'd5;
      repeat (2) begin
        @(negedge clk);
        if (wr_en) nwr++;
        @(posedge clk); #1;
      end
      reset = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      check("rstmid_ready_low", in_ready, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 16; c++) begin
        in_valid = (sent < 4); a_in = 8'd1; b_in = 8'd1;
        @(negedge clk);
        if (in_valid && in_ready) sent++;
        if (wr_en) begin nwr++; last_d = data_out; end
        @(posedge clk); #1;
      end
      check("rstmid_nwr", nwr, 1);
      check("rstmid_data", last_d, 4);
    end

    // Modulo wrap on the 16-bit instance.
    begin
      int idx = 0;
      logic [15:0] got[$];
      int pa[8] = '{-128, -128, -128, -128, -1, -1, -1, -1};
      int pb[8] = '{-128, -128, -128, -128, 1, 1, 1, 1};
      for (int c = 0; c < 20; c++) begin
        w_valid = (idx < 8);
        if (idx < 8) begin w_a = INW'(pa[idx]); w_b = INW'(pb[idx]); end
        @(negedge clk);
        if (w_valid && w_ready) idx++;
        if (w_wr) got.push_back(w_data);
        @(posedge clk); #1;
      end
      check("wrap_nwr", got.size(), 2);
      if (got.size() == 2) begin
        check("wrap_data0", got[0], 16'h0000);
        check("wrap_data1", got[1], 16'hFFFC);
      end
    end

    // Random soak: group-sum model plus FIFO occupancy model driving capacity.
    begin
      int exp_q[$];
      int fifo_cnt = 0, grp_sum = 0, grp_n = 0, accepted = 0, cyc = 0, nwr = 0;
      bit slow = 1'b0;
      do_reset();
      while (accepted < 10000 && cyc < 80000) begin
        if (cyc % 200 == 0) slow = ~slow;
        in_valid = ($urandom_range(0, 3) != 0);
        a_in = INW'($urandom); b_in = INW'($urandom);
        capacity = CAPW'(DEPTH - fifo_cnt);
        @(negedge clk);
        if (in_valid && in_ready) begin
          grp_sum = (grp_sum + int'($signed(a_in)) * int'($signed(b_in))) & mask;
          grp_n++; accepted++;
          if (grp_n == K) begin exp_q.push_back(grp_sum); grp_sum = 0; grp_n = 0; end
        end
        if (wr_en) begin
          nwr++;
          check("soak_wr_with_capacity", capacity != '0, 1);
          if (exp_q.size() == 0) check("soak_unexpected_write", 1, 0);
          else check($sformatf("soak_result%0d", nwr), data_out, exp_q.pop_front());
          if (fifo_cnt < DEPTH) fifo_cnt++;
        end
        if (fifo_cnt > 0 && $urandom_range(0, slow ? 7 : 1) == 0) fifo_cnt--;
        @(posedge clk); #1;
        cyc++;
      end
      check("soak_accepted", accepted, 10000);
      in_valid = 1'b0;
      for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
        capacity = CAPW'(DEPTH - fifo_cnt);
        @(negedge clk);
        if (wr_en) begin
          nwr++;
          check("soak_wr_with_capacity", capacity != '0, 1);
          check($sformatf("soak_result%0d", nwr), data_out, exp_q.pop_front());
          if (fifo_cnt < DEPTH) fifo_cnt++;
        end
        if (fifo_cnt > 0) fifo_cnt--;
        @(posedge clk); #1;
      end
      check("soak_drained", exp_q.size(), 0);
      check("soak_nwr", nwr, 2500);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_fifo_writer.md
# mac_fifo_writer

Streaming multiply-accumulate stage that sits directly upstream of `fifo_out`. It accepts signed operand pairs on a valid/ready input and sums every `K` consecutive products into one result. Each result is written into `fifo_out` through its `data_in`/`wr_en` port, and the FIFO's `capacity` output provides backpressure. The block never writes when `capacity == 0`, and it stalls its input rather than drop a result.

## Interface
- `INW`, default 8: bits per signed operand.
- `OUTW`, default 24: bits per result; matches `fifo_out` `OUTW`.
- `K`, default 4: products per result; K ≥ 1.
- `DEPTH`, default 8: depth of the downstream `fifo_out`; sets the `capacity` width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_in`  in  INW  signed operand A.
- `b_in`  in  INW  signed operand B.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  stage can accept a pair this cycle.
- `data_out`  out  OUTW  result; connects to `fifo_out.data_in`.
- `wr_en`  out  1  write strobe; connects to `fifo_out.wr_en`.
- `capacity`  in  $clog2(DEPTH+1)  free entries reported by `fifo_out`.

## Operation
- **Accept.** A pair is accepted on an edge where `in_valid && in_ready`.
- **Group counter.** `cnt` runs 0..K-1 and increments per accepted pair, wrapping to 0 after K-1. The pair taken at `cnt == K-1` is tagged "last"; the pair taken at `cnt == 0` is tagged "first".
- **Stage P (product register).** Holds `prod = a*b`, signed and 2·INW bits wide, plus `p_valid`, `p_first` and `p_last`.
- **Stage A (accumulator).** When `p_valid` is set on an advancing edge:
  - `sum = (p_first ? 0 : acc) + ext(prod)`, where `ext` sign-extends (or truncates) `prod` to OUTW bits.
  - Addition is modulo 2^OUTW; there is no saturation and no overflow flag.
  - `acc <= sum`.
  - If `p_last`: `res <= sum` and `res_valid <= 1`.
- **Output.**
  - `wr_en = res_valid && (capacity != 0)`.
  - `data_out = res`.
  - `res_valid` clears on an edge where `wr_en == 1`, unless a new last product lands on that same edge, in which case it stays 1 with the new `res`.
- **Advance enable.** `en = !res_valid || (capacity != 0)`.
  - P, A, `cnt` and `res` update only when `en == 1`.
  - `in_ready = en && !reset`.
  - When `en == 0`, all state holds, including `p_*`.
- **Reset.** `cnt = 0`, `p_valid = 0`, `acc = 0`, `res = 0`, `res_valid = 0`. A partially accumulated group is discarded.

## Timing
- **Output reset values:** `in_ready = 0` while `reset` is high; `wr_en = 0`; `data_out = 0`.
- **First cycle after reset:** `in_ready = 1`.
- **Latency:** last pair accepted at edge t → `res_valid` high after edge t+1 → `wr_en` high in the cycle after edge t+1 (if `capacity != 0`) → the FIFO captures the result at edge t+2.
- **Throughput:** one pair per cycle whenever `capacity != 0`, including back-to-back groups. With K = 1, one result is produced per cycle.
- **Stall:** when `res_valid && capacity == 0`:
  - `in_ready = 0` and `wr_en = 0`; nothing advances.
  - Resume is combinational: in the first cycle with `capacity != 0`, both `wr_en` and `in_ready` are 1.
- **Capacity drops mid-group:** input continues to be accepted until a result is actually pending.
- **Simultaneous write and arrival:** `wr_en` and a new last product arriving on the same edge is legal. The old result is written and the new one replaces it with no gap.
- **Reset mid-group or while a result is pending:** everything is flushed. No `wr_en` is issued for the flushed data.

## Test plan
- **Basic sum.** INW=8, OUTW=24, K=4, `capacity=8`. Pairs (1,1),(2,3),(-1,5),(4,4) sent back-to-back → one `wr_en` pulse, `data_out = 18`, exactly 1 cycle after the 4th accept.
- **Throughput.** Three back-to-back groups of (1,1)×4, `in_valid` held high → `in_ready` stays 1 → writes of 4, 4, 4, spaced 4 cycles apart.
- **Backpressure.** `capacity` forced to 0 while the (1,1)×4 group completes → `wr_en = 0` and `in_ready = 0`, held for 10 cycles with `data_out` stable at 4. Set `capacity = 1` → `wr_en = 1` the same cycle and `in_ready = 1`.
- **Wrap.** OUTW=16, K=4, four pairs of (-128,-128) → `data_out = 0x0000` (65536 mod 2^16). Next group (-1,1)×4 → `data_out = 0xFFFC`.
- **Reset mid-group.** Accept 2 pairs of (5,5), assert `reset` for 1 cycle, then send (1,1)×4 → only one write, with `data_out = 4`.
- **Random soak.** Random `in_valid`, random `capacity` driven by a `fifo_out` model, 10000 pairs → every result matches a golden model, and there is no `wr_en` while `capacity == 0`.
